// File: rtl/traffic_light_fsm.sv
// traffic_light_fsm: main/side road light sequencer timed by a 1 Hz strobe.
// Main green is held until a side-road vehicle has been seen; phase timing
// is counted in whole enable_1Hz ticks. All outputs are registered.
module traffic_light_fsm #(
  parameter int unsigned T_MAIN_GREEN = 10,
  parameter int unsigned T_SIDE_GREEN = 6,
  parameter int unsigned T_YELLOW     = 3,
  parameter int unsigned T_ALL_RED    = 1
) (
  input  logic       clk,
  input  logic       global_reset,
  input  logic       enable_1Hz,
  input  logic       side_sensor,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic [2:0] phase,
  output logic [7:0] sec_cnt
);

  localparam int unsigned CNT_W = 8;

  localparam logic [2:0] S_MG  = 3'd0;
  localparam logic [2:0] S_MY  = 3'd1;
  localparam logic [2:0] S_AR1 = 3'd2;
  localparam logic [2:0] S_SG  = 3'd3;
  localparam logic [2:0] S_SY  = 3'd4;
  localparam logic [2:0] S_AR2 = 3'd5;

  // Lamp encodings {red, yellow, green}
  localparam logic [2:0] L_RED    = 3'b100;
  localparam logic [2:0] L_YELLOW = 3'b010;
  localparam logic [2:0] L_GREEN  = 3'b001;

  // Last counter value of each phase (the value seen on its final tick)
  localparam logic [CNT_W-1:0] LAST_MG  = CNT_W'(T_MAIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LAST_SG  = CNT_W'(T_SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] LAST_Y   = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LAST_AR  = CNT_W'(T_ALL_RED - 1);

  logic [2:0]       r_state;
  logic [2:0]       w_next_state;
  logic [CNT_W-1:0] r_sec_cnt;
  logic [CNT_W-1:0] w_sec_cnt_nxt;
  logic             r_side_req;
  logic             w_side_req_nxt;
  logic             w_request;
  logic             w_state_change;
  logic             w_mg_saturated;
  logic [2:0]       r_main_light;
  logic [2:0]       r_side_light;
  logic [2:0]       w_main_light_nxt;
  logic [2:0]       w_side_light_nxt;

  assign w_request      = r_side_req | side_sensor;
  assign w_state_change = (w_next_state != r_state);
  assign w_mg_saturated = (r_state == S_MG) && (r_sec_cnt == LAST_MG);

  // State register
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      r_state <= S_AR2;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: phase advances only on a tick at the phase's last count
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_MG: begin
        if (enable_1Hz && (r_sec_cnt == LAST_MG) && w_request) begin
          w_next_state = S_MY;
        end
      end
      S_MY: begin
        if (enable_1Hz && (r_sec_cnt == LAST_Y)) begin
          w_next_state = S_AR1;
        end
      end
      S_AR1: begin
        if (enable_1Hz && (r_sec_cnt == LAST_AR)) begin
          w_next_state = S_SG;
        end
      end
      S_SG: begin
        if (enable_1Hz && (r_sec_cnt == LAST_SG)) begin
          w_next_state = S_SY;
        end
      end
      S_SY: begin
        if (enable_1Hz && (r_sec_cnt == LAST_Y)) begin
          w_next_state = S_AR2;
        end
      end
      S_AR2: begin
        if (enable_1Hz && (r_sec_cnt == LAST_AR)) begin
          w_next_state = S_MG;
        end
      end
      // Illegal encodings recover to all-red unconditionally
      default: begin
        w_next_state = S_AR2;
      end
    endcase
  end

  // Seconds counter next value: clear on phase change, saturate in MG
  always_comb begin
    w_sec_cnt_nxt = r_sec_cnt;
    if (w_state_change) begin
      w_sec_cnt_nxt = '0;
    end else if (enable_1Hz && !w_mg_saturated) begin
      w_sec_cnt_nxt = r_sec_cnt + CNT_W'(1);
    end
  end

  // Side request latch next value: clearing on SG entry beats a new sensor hit
  always_comb begin
    w_side_req_nxt = r_side_req | side_sensor;
    if ((r_state == S_AR1) && (w_next_state == S_SG)) begin
      w_side_req_nxt = 1'b0;
    end
  end

  // Output decode from the next state so lamps move on the same edge as phase
  always_comb begin
    w_main_light_nxt = L_RED;
    w_side_light_nxt = L_RED;
    case (w_next_state)
      S_MG:    w_main_light_nxt = L_GREEN;
      S_MY:    w_main_light_nxt = L_YELLOW;
      S_SG:    w_side_light_nxt = L_GREEN;
      S_SY:    w_side_light_nxt = L_YELLOW;
      default: begin
        w_main_light_nxt = L_RED;
        w_side_light_nxt = L_RED;
      end
    endcase
  end

  // Counter, request latch and lamp registers
  always_ff @(posedge clk or posedge global_reset) begin
    if (global_reset) begin
      r_sec_cnt    <= '0;
      r_side_req   <= 1'b0;
      r_main_light <= L_RED;
      r_side_light <= L_RED;
    end else begin
      r_sec_cnt    <= w_sec_cnt_nxt;
      r_side_req   <= w_side_req_nxt;
      r_main_light <= w_main_light_nxt;
      r_side_light <= w_side_light_nxt;
    end
  end

  assign phase      = r_state;
  assign sec_cnt    = r_sec_cnt;
  assign main_light = r_main_light;
  assign side_light = r_side_light;

endmodule

// File: tb/tb_traffic_light_fsm.sv
// Directed bench for traffic_light_fsm with default timing parameters.
module tb_traffic_light_fsm;

  localparam logic [2:0] MG  = 3'd0;
  localparam logic [2:0] MY  = 3'd1;
  localparam logic [2:0] AR1 = 3'd2;
  localparam logic [2:0] SG  = 3'd3;
  localparam logic [2:0] SY  = 3'd4;
  localparam logic [2:0] AR2 = 3'd5;

  logic       clk;
  logic       global_reset;
  logic       enable_1Hz;
  logic       side_sensor;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic [2:0] phase;
  logic [7:0] sec_cnt;

  int n_pass;
  int n_total;

  logic [2:0] seq_ph  [6];
  int         seq_dur [6];

  traffic_light_fsm dut (
    .clk          (clk),
    .global_reset (global_reset),
    .enable_1Hz   (enable_1Hz),
    .side_sensor  (side_sensor),
    .main_light   (main_light),
    .side_light   (side_light),
    .phase        (phase),
    .sec_cnt      (sec_cnt)
  );

  // 50 MHz clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Expected lamps {main, side} for a given phase
  function automatic logic [5:0] lamps_for(input logic [2:0] ph);
    case (ph)
      MG:      return 6'b001_100;
      MY:      return 6'b010_100;
      SG:      return 6'b100_001;
      SY:      return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic chk(input string tag, input logic [2:0] ph, input logic [7:0] sc);
    logic [5:0] l;
    l = lamps_for(ph);
    cmp({tag, ".phase"}, 8'(phase), 8'(ph));
    cmp({tag, ".sec_cnt"}, sec_cnt, sc);
    cmp({tag, ".main_light"}, 8'(main_light), 8'(l[5:3]));
    cmp({tag, ".side_light"}, 8'(side_light), 8'(l[2:0]));
  endtask

  // One strobe, preceded by idle cycles; returns on the negedge after it
  task automatic tick();
    repeat (2) @(negedge clk);
    enable_1Hz = 1'b1;
    @(negedge clk);
    enable_1Hz = 1'b0;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Strobe with the sensor raised on the same cycle
  task automatic tick_sensor();
    repeat (2) @(negedge clk);
    enable_1Hz  = 1'b1;
    side_sensor = 1'b1;
    @(negedge clk);
    enable_1Hz  = 1'b0;
    side_sensor = 1'b0;
  endtask

  // Single-cycle sensor pulse between ticks
  task automatic pulse_sensor();
    @(negedge clk);
    side_sensor = 1'b1;
    @(negedge clk);
    side_sensor = 1'b0;
  endtask

  // 20 ns reset pulse starting at a negedge; checks the asynchronous effect
  task automatic reset_pulse(input string tag);
    @(negedge clk);
    global_reset = 1'b1;
    #1;
    chk(tag, AR2, 8'd0);
    #19;
    global_reset = 1'b0;
  endtask

  // Lamp safety invariants on every cycle
  always @(negedge clk) begin
    cmp("inv.main_onehot", 8'($onehot(main_light)), 8'd1);
    cmp("inv.side_onehot", 8'($onehot(side_light)), 8'd1);
    cmp("inv.one_red", 8'(main_light[2] | side_light[2]), 8'd1);
    cmp("inv.phase_legal", 8'(phase < 3'd6), 8'd1);
  end

  initial begin
    n_pass  = 0;
    n_total = 0;
    seq_ph  = '{MY, AR1, SG, SY, AR2, MG};
    seq_dur = '{3, 1, 6, 3, 1, 10};
    global_reset = 1'b1;
    enable_1Hz   = 1'b0;
    side_sensor  = 1'b0;

    // Reset and power-up sequence with no traffic
    repeat (3) @(negedge clk);
    chk("reset", AR2, 8'd0);
    global_reset = 1'b0;
    @(negedge clk);
    chk("post_release_idle", AR2, 8'd0);
    tick();
    chk("ar2_to_mg", MG, 8'd0);
    tick_n(9);
    chk("mg_sec9", MG, 8'd9);
    tick_n(5);
    chk("mg_saturated", MG, 8'd9);

    // Sensor on the same cycle as the deciding tick
    tick_sensor();
    chk("same_cycle_to_my", MY, 8'd0);
    tick_n(2);
    chk("my_sec2", MY, 8'd2);
    tick();
    chk("my_to_ar1", AR1, 8'd0);
    tick();
    chk("ar1_to_sg", SG, 8'd0);
    tick_n(5);
    chk("sg_sec5", SG, 8'd5);
    tick();
    chk("sg_to_sy", SY, 8'd0);
    tick();
    chk("sy_sec1", SY, 8'd1);

    // Reset mid-yellow aborts to all-red, then normal restart
    reset_pulse("reset_in_sy");
    chk("after_reset_pulse", AR2, 8'd0);
    tick();
    chk("rst_ar2_to_mg", MG, 8'd0);

    // Short sensor pulse between ticks at MG second 3
    tick_n(3);
    chk("mg_sec3", MG, 8'd3);
    pulse_sensor();
    chk("pulse_no_tick", MG, 8'd3);
    tick_n(6);
    chk("pulse_mg_sec9", MG, 8'd9);
    tick();
    chk("pulse_to_my", MY, 8'd0);
    tick_n(3);
    chk("cycle_ar1", AR1, 8'd0);
    tick();
    chk("cycle_sg", SG, 8'd0);
    pulse_sensor();
    tick_n(6);
    chk("cycle_sy", SY, 8'd0);
    tick_n(3);
    chk("cycle_ar2", AR2, 8'd0);
    tick();
    chk("cycle_mg", MG, 8'd0);
    tick_n(9);
    chk("relatched_mg_sec9", MG, 8'd9);
    tick();
    chk("relatched_min_dwell", MY, 8'd0);

    // Sensor held high: two full 24-tick cycles, no extra MG dwell
    side_sensor = 1'b1;
    for (int c = 0; c < 2; c++) begin
      for (int p = 0; p < 6; p++) begin
        for (int k = 0; k < seq_dur[p]; k++) begin
          chk("continuous", seq_ph[p], 8'(k));
          tick();
        end
      end
    end
    chk("continuous_wrap", MY, 8'd0);

    // Reset with the request latch set must clear it
    side_sensor = 1'b0;
    reset_pulse("reset_clears_req");
    tick();
    chk("req_cleared_mg", MG, 8'd0);
    tick_n(12);
    chk("req_cleared_hold", MG, 8'd9);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/traffic_light_fsm.md
# traffic_light_fsm

Two-road intersection light sequencer (main road / side road) that sits directly downstream of the `Divider` block. It consumes the single-cycle `enable_1Hz` strobe as its time base and counts phase durations in whole seconds. It holds main-road green until a side-road vehicle is detected. All outputs are registered Moore outputs that drive the lamp drivers.

## Interface

Parameters:
- `T_MAIN_GREEN`, default 10: minimum main-road green, in seconds (ticks). Must be 1..255.
- `T_SIDE_GREEN`, default 6: side-road green, in seconds. Must be 1..255.
- `T_YELLOW`, default 3: yellow duration for either road. Must be 1..255.
- `T_ALL_RED`, default 1: all-red clearance between greens. Must be 1..255.

Ports:
- `clk`, input, 1: system clock, 50 MHz. Single clock domain.
- `global_reset`, input, 1: asynchronous, active-high reset.
- `enable_1Hz`, input, 1: one-`clk`-wide strobe from `Divider`, once per second.
- `side_sensor`, input, 1: side-road vehicle present. Level input, already synchronous to `clk`.
- `main_light`, output, 3: `{red, yellow, green}`, one-hot.
- `side_light`, output, 3: `{red, yellow, green}`, one-hot.
- `phase`, output, 3: current state encoding, for debug and testbench.
- `sec_cnt`, output, 8: seconds elapsed in the current phase.

## Operation

States and their `phase` encodings:
- `MG`=0: main green, side red.
- `MY`=1: main yellow, side red.
- `AR1`=2: all red, before side green.
- `SG`=3: side green, main red.
- `SY`=4: side yellow, main red.
- `AR2`=5: all red, before main green.
- Encodings 6 and 7 are illegal. If either is ever reached, the next `clk` edge goes to `AR2` with `sec_cnt`=0.

Transitions (all evaluated only on a `clk` edge where `enable_1Hz`=1):
- `MG`→`MY` when `sec_cnt`==`T_MAIN_GREEN`-1 and (`side_req` or `side_sensor`). Otherwise `MG` is held.
- `MY`→`AR1` when `sec_cnt`==`T_YELLOW`-1.
- `AR1`→`SG` when `sec_cnt`==`T_ALL_RED`-1.
- `SG`→`SY` when `sec_cnt`==`T_SIDE_GREEN`-1.
- `SY`→`AR2` when `sec_cnt`==`T_YELLOW`-1.
- `AR2`→`MG` when `sec_cnt`==`T_ALL_RED`-1.

Second counter (`sec_cnt`):
- Increments by 1 on each `enable_1Hz` tick.
- Clears to 0 on the same edge as any state transition.
- In `MG`, saturates at `T_MAIN_GREEN`-1 while no request is pending. It never wraps.

Side request latch (`side_req`, internal):
- Set on any `clk` edge where `side_sensor`=1, independent of `enable_1Hz`.
- Cleared on the edge that enters `SG`. If the sensor is high on that same edge, clear wins.
- `side_sensor` high during `SG`, `SY` or `AR2` re-sets the latch after that edge, so the next `MG` ends at its minimum duration.

Lamp outputs:
- Decoded from the next-state value and registered, so lamps change on the same edge as `phase`.
- Exactly one bit of each light vector is high at all times.
- At least one road shows red at all times.

## Timing

Reset:
- While `global_reset` is high, asynchronously: `phase`=`AR2`, `sec_cnt`=0, `side_req`=0, `main_light`=3'b100, `side_light`=3'b100.
- A reset mid-phase aborts that phase immediately. No partial yellow is completed.

After reset release:
- The first `T_ALL_RED` ticks are spent in `AR2`, then the block enters `MG`.

Phase durations:
- Each phase lasts exactly its parameter count of `enable_1Hz` ticks. With a 1 s strobe that is N seconds, ±1 clk.
- Minimum `MG` dwell is `T_MAIN_GREEN` ticks.

Edge cases:
- A sensor pulse of a single `clk` cycle, landing anywhere (including between ticks), must be captured.
- `enable_1Hz` held high for several cycles (a `Divider` fault) is treated as one tick per cycle. No special filtering is required.
- Latency from the deciding tick edge to the lamp change is 0 cycles: registered on that edge.

## Test plan

- Reset release, `side_sensor`=0 → `AR2` for 1 tick, then `MG`. `MG` is held indefinitely with `sec_cnt` saturated at 9 and `main_light`=3'b001.
- `side_sensor` pulsed for 1 clk at tick 3 of `MG` → `MY` entered exactly at tick 10. Then 3 ticks `MY`, 1 tick `AR1`, 6 ticks `SG` (`side_light`=3'b001), 3 ticks `SY`, 1 tick `AR2`, back to `MG`.
- `side_sensor` asserted on the same cycle as the tick where `sec_cnt`=9 in `MG`, with `side_req`=0 → transition to `MY` on that edge.
- `side_sensor` held high continuously → repeating 24-tick cycle (10+3+1+6+3+1) with no extra `MG` dwell.
- `global_reset` pulsed for 20 ns during `SY` with `sec_cnt`=1 → immediately `phase`=5 and both lights 3'b100. Then normal sequence from `AR2`.
- Every clk across all runs → assertions hold: both light vectors one-hot, never both non-red, `phase` never 6 or 7.
